// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI write arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_B,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         CNT_W       = 16;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NUM_M = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   k;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_M; i++) begin
      k = (int'(ptr_i) + i) % NUM_M;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin write arbiter: NUM_M AW/W/B masters onto one single-outstanding slave port.
// State table:
//   IDLE   | no burst; arbitrate among S_AWVALID requesters
//   ADDR   | granted master's address phase forwarded to slave
//   DATA   | granted master's data beats forwarded until WLAST beat
//   WAIT_B | waiting for the slave's one-cycle BVALID pulse
//   RESP   | captured response held to granted master until BREADY
// Optional build macro AXI_WR_ARB_STATS_EN adds STAT_BURSTS, per-master
// 16-bit saturating completed-burst counters.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NUM_M*ADDR_W-1:0] S_AWADDR,
  input  logic [NUM_M-1:0]        S_AWVALID,
  output logic [NUM_M-1:0]        S_AWREADY,
  input  logic [NUM_M*DATA_W-1:0] S_WDATA,
  input  logic [NUM_M-1:0]        S_WVALID,
  input  logic [NUM_M-1:0]        S_WLAST,
  output logic [NUM_M-1:0]        S_WREADY,
  output logic [NUM_M-1:0]        S_BVALID,
  output logic [1:0]              S_BRESP,
  input  logic [NUM_M-1:0]        S_BREADY,
  output logic [ADDR_W-1:0]       M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_W-1:0]       M_WDATA,
  output logic                    M_WVALID,
  output logic                    M_WLAST,
  input  logic                    M_WREADY,
  input  logic                    M_BVALID,
  input  logic [1:0]              M_BRESP
`ifdef AXI_WR_ARB_STATS_EN
  ,
  output logic [NUM_M*CNT_W-1:0]  STAT_BURSTS
`endif
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_M-1:0]    pick_gnt;
  logic [IDX_W-1:0]    pick_idx;

  rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i (S_AWVALID),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign M_AWADDR = addr_q;

  // State and burst-context registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      bresp_q <= bresp_d;
    end
  end

  // Next state and routing; only the granted master's lane is ever connected.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    bresp_d   = bresp_q;
    S_AWREADY = '0;
    S_WREADY  = '0;
    S_BVALID  = '0;
    S_BRESP   = RESP_OKAY;
    M_AWVALID = 1'b0;
    M_WDATA   = '0;
    M_WVALID  = 1'b0;
    M_WLAST   = 1'b0;
    case (state_q)
      IDLE: begin
        // Address is preloaded at grant so M_AWADDR is already valid in ADDR.
        if (|pick_gnt) begin
          grant_d = pick_idx;
          addr_d  = S_AWADDR[pick_idx*ADDR_W +: ADDR_W];
          state_d = ADDR;
        end
      end
      ADDR: begin
        M_AWVALID          = S_AWVALID[grant_q];
        S_AWREADY[grant_q] = M_AWREADY;
        if (S_AWVALID[grant_q] && M_AWREADY) begin
          addr_d  = S_AWADDR[grant_q*ADDR_W +: ADDR_W];
          state_d = DATA;
        end
      end
      DATA: begin
        M_WDATA           = S_WDATA[grant_q*DATA_W +: DATA_W];
        M_WVALID          = S_WVALID[grant_q];
        M_WLAST           = S_WLAST[grant_q];
        S_WREADY[grant_q] = M_WREADY;
        if (S_WVALID[grant_q] && M_WREADY && S_WLAST[grant_q]) begin
          // The slave may pulse BVALID on the very cycle of the last beat.
          if (M_BVALID) begin
            bresp_d = M_BRESP;
            state_d = RESP;
          end else begin
            state_d = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        if (M_BVALID) begin
          bresp_d = M_BRESP;
          state_d = RESP;
        end
      end
      RESP: begin
        S_BVALID[grant_q] = 1'b1;
        S_BRESP           = bresp_q;
        if (S_BREADY[grant_q]) begin
          ptr_d   = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXI_WR_ARB_STATS_EN
  logic             burst_done;
  logic [CNT_W-1:0] cnt_q [NUM_M];

  assign burst_done = (state_q == RESP) && S_BREADY[grant_q];

  // Per-master completed-burst counters, saturating at all ones.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_M; i++) cnt_q[i] <= '0;
    end else if (burst_done && (cnt_q[grant_q] != '1)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_stat
    assign STAT_BURSTS[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter with two masters.
module tb_axi_wr_arbiter;

  localparam int NUM_M  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                    ACLK = 1'b0;
  logic                    ARESETn;
  logic [NUM_M*ADDR_W-1:0] S_AWADDR;
  logic [NUM_M-1:0]        S_AWVALID;
  logic [NUM_M-1:0]        S_AWREADY;
  logic [NUM_M*DATA_W-1:0] S_WDATA;
  logic [NUM_M-1:0]        S_WVALID;
  logic [NUM_M-1:0]        S_WLAST;
  logic [NUM_M-1:0]        S_WREADY;
  logic [NUM_M-1:0]        S_BVALID;
  logic [1:0]              S_BRESP;
  logic [NUM_M-1:0]        S_BREADY;
  logic [ADDR_W-1:0]       M_AWADDR;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [DATA_W-1:0]       M_WDATA;
  logic                    M_WVALID;
  logic                    M_WLAST;
  logic                    M_WREADY;
  logic                    M_BVALID;
  logic [1:0]              M_BRESP;
`ifdef AXI_WR_ARB_STATS_EN
  logic [NUM_M*16-1:0]     STAT_BURSTS;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] beat_q[$];
  logic [31:0] awa_q[$];
  bit          last_q[$];

  axi_wr_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .S_AWADDR  (S_AWADDR),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WVALID  (S_WVALID),
    .S_WLAST   (S_WLAST),
    .S_WREADY  (S_WREADY),
    .S_BVALID  (S_BVALID),
    .S_BRESP   (S_BRESP),
    .S_BREADY  (S_BREADY),
    .M_AWADDR  (M_AWADDR),
    .M_AWVALID (M_AWVALID),
    .M_AWREADY (M_AWREADY),
    .M_WDATA   (M_WDATA),
    .M_WVALID  (M_WVALID),
    .M_WLAST   (M_WLAST),
    .M_WREADY  (M_WREADY),
    .M_BVALID  (M_BVALID),
    .M_BRESP   (M_BRESP)
`ifdef AXI_WR_ARB_STATS_EN
    ,
    .STAT_BURSTS (STAT_BURSTS)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Slave-side beat recorder; inputs change 1ns after posedge, so negedge is stable.
  always @(negedge ACLK) begin
    if (ARESETn && M_WVALID && M_WREADY) begin
      beat_q.push_back(M_WDATA);
      awa_q.push_back(M_AWADDR);
      last_q.push_back(M_WLAST);
    end
  end

  task automatic clear_inputs();
    S_AWADDR  = '0;
    S_AWVALID = '0;
    S_WDATA   = '0;
    S_WVALID  = '0;
    S_WLAST   = '0;
    S_BREADY  = '0;
    M_AWREADY = 1'b1;
    M_WREADY  = 1'b1;
    M_BVALID  = 1'b0;
    M_BRESP   = 2'b00;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    beat_q.delete();
    awa_q.delete();
    last_q.delete();
  endtask

  // Drives one burst from master m, playing the slave side too. Called and
  // returns at posedge+1. Reports timeouts, cross-lane activity, stall and
  // response-hold problems back to the caller.
  task automatic run_burst(input int m, input logic [31:0] addr, input int nbeats,
                           input logic [31:0] dbase, input int stall_at, input int stall_len,
                           input int bdelay, input logic [1:0] bresp, input bit bv_with_last,
                           input int abort_after, output int to_cnt, output int xtalk,
                           output int stall_bad, output int hold_bad);
    int o;
    bit done;
    o = (m == 0) ? 1 : 0;
    to_cnt = 0; xtalk = 0; stall_bad = 0; hold_bad = 0;
    S_AWADDR[m*ADDR_W +: ADDR_W] = addr;
    S_AWVALID[m] = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      #1;
      if (S_AWREADY[m] && M_AWVALID) done = 1'b1;
      if (S_AWREADY[o] || S_WREADY[o] || S_BVALID[o]) xtalk++;
      @(posedge ACLK); #1;
    end
    if (!done) to_cnt++;
    S_AWVALID[m] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_after) return;
      S_WDATA[m*DATA_W +: DATA_W] = dbase + i;
      S_WVALID[m] = 1'b1;
      S_WLAST[m]  = (i == nbeats - 1);
      M_BVALID    = bv_with_last && (i == nbeats - 1);
      M_BRESP     = bresp;
      if (i == stall_at) begin
        M_WREADY = 1'b0;
        repeat (stall_len) begin
          #1;
          if (S_WREADY[m] !== 1'b0 || M_WVALID !== 1'b1) stall_bad++;
          @(posedge ACLK); #1;
        end
        M_WREADY = 1'b1;
      end
      done = 1'b0;
      for (int t = 0; t < 30 && !done; t++) begin
        #1;
        if (S_WREADY[m]) done = 1'b1;
        if (S_AWREADY[o] || S_WREADY[o] || S_BVALID[o]) xtalk++;
        @(posedge ACLK); #1;
      end
      if (!done) to_cnt++;
    end
    S_WVALID[m] = 1'b0;
    S_WLAST[m]  = 1'b0;
    M_BVALID    = 1'b0;
    if (!bv_with_last) begin
      M_BVALID = 1'b1;
      M_BRESP  = bresp;
      @(posedge ACLK); #1;
      M_BVALID = 1'b0;
    end
    M_BRESP = 2'b00;
    for (int d = 0; d < bdelay; d++) begin
      #1;
      if (S_BVALID[m] !== 1'b1 || S_BRESP !== bresp) hold_bad++;
      if (S_AWREADY[o] || S_WREADY[o] || S_BVALID[o]) xtalk++;
      @(posedge ACLK); #1;
    end
    S_BREADY[m] = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      #1;
      if (S_BVALID[m]) begin
        done = 1'b1;
        if (S_BRESP !== bresp) hold_bad++;
      end
      @(posedge ACLK); #1;
    end
    if (!done) to_cnt++;
    S_BREADY[m] = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    clear_inputs();
    S_AWVALID = 2'b11;
    repeat (3) @(posedge ACLK);
    #1;
    n_checks++; if (S_AWREADY !== 2'b00) begin n_fail++; $display("FAIL reset_awready: got %b expected 00", S_AWREADY); end
    n_checks++; if (S_WREADY !== 2'b00) begin n_fail++; $display("FAIL reset_wready: got %b expected 00", S_WREADY); end
    n_checks++; if (S_BVALID !== 2'b00 || S_BRESP !== 2'b00) begin n_fail++; $display("FAIL reset_b: got bvalid=%b bresp=%b expected 00/00", S_BVALID, S_BRESP); end
    n_checks++; if ({M_AWVALID, M_WVALID, M_WLAST} !== 3'b000) begin n_fail++; $display("FAIL reset_mvalid: got %b expected 000", {M_AWVALID, M_WVALID, M_WLAST}); end
    n_checks++; if (M_AWADDR !== 32'h0) begin n_fail++; $display("FAIL reset_awaddr: got %h expected 0", M_AWADDR); end
    S_AWVALID = 2'b00;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_single();
    int to, xt, sb, hb;
    beat_q.delete(); awa_q.delete(); last_q.delete();
    run_burst(0, 32'h10, 4, 32'hA0, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0 || xt !== 0) begin n_fail++; $display("FAIL single_flow: got timeouts=%0d xtalk=%0d expected 0/0", to, xt); end
    n_checks++; if (beat_q.size() !== 4) begin n_fail++; $display("FAIL single_nbeats: got %0d expected 4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== 32'hA0 + i || awa_q[i] !== 32'h10 || last_q[i] !== (i == 3)) begin
        n_fail++; $display("FAIL single_beat%0d: got data=%h addr=%h last=%0d expected %h/10/%0d", i, beat_q[i], awa_q[i], last_q[i], 32'hA0 + i, (i == 3));
      end
    end
    n_checks++; if (hb !== 0) begin n_fail++; $display("FAIL single_bresp: got %0d bad response samples expected 0", hb); end
    S_AWADDR = {32'h200, 32'h100};
    S_AWVALID = 2'b11;
    @(posedge ACLK); #1;
    n_checks++; if (S_AWREADY !== 2'b10 || M_AWADDR !== 32'h200) begin n_fail++; $display("FAIL single_ptr: got awready=%b awaddr=%h expected 10/200", S_AWREADY, M_AWADDR); end
    run_burst(1, 32'h200, 1, 32'hB0, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    run_burst(0, 32'h100, 1, 32'hC0, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0) begin n_fail++; $display("FAIL single_followup: got timeouts=%0d expected 0", to); end
  endtask

  task automatic test_round_robin();
    int to, xt, sb, hb, tot_to, tot_xt;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h1000; exp_d[1] = 32'h2000; exp_d[2] = 32'h3000; exp_d[3] = 32'h4000;
    tot_to = 0; tot_xt = 0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      S_AWADDR = {32'h2200, 32'h1100};
      S_AWVALID = 2'b11;
      run_burst(0, 32'h1100, 1, exp_d[2*r], -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
      tot_to += to; tot_xt += xt;
      run_burst(1, 32'h2200, 1, exp_d[2*r+1], -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
      tot_to += to; tot_xt += xt;
    end
    n_checks++; if (tot_to !== 0 || tot_xt !== 0) begin n_fail++; $display("FAIL rr_order: got timeouts=%0d xtalk=%0d expected 0/0", tot_to, tot_xt); end
    n_checks++; if (beat_q.size() !== 4) begin n_fail++; $display("FAIL rr_nbeats: got %0d expected 4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL rr_beat%0d: got %h expected %h", i, beat_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    int to, xt, sb, hb;
    beat_q.delete(); awa_q.delete(); last_q.delete();
    run_burst(1, 32'h300, 4, 32'h70, 2, 3, 5, 2'b10, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0 || sb !== 0) begin n_fail++; $display("FAIL bp_stall: got timeouts=%0d stall_errs=%0d expected 0/0", to, sb); end
    n_checks++; if (hb !== 0) begin n_fail++; $display("FAIL bp_bhold: got %0d bad response samples expected 0", hb); end
    n_checks++; if (beat_q.size() !== 4) begin n_fail++; $display("FAIL bp_nbeats: got %0d expected 4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== 32'h70 + i) begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", i, beat_q[i], 32'h70 + i); end
    end
  endtask

  task automatic test_isolation();
    int to, xt, sb, hb;
    beat_q.delete(); awa_q.delete(); last_q.delete();
    S_AWADDR[ADDR_W +: ADDR_W] = 32'h900;
    S_AWVALID[1] = 1'b1;
    S_WDATA[DATA_W +: DATA_W] = 32'hDEADBEEF;
    S_WVALID[1] = 1'b1;
    S_WLAST[1]  = 1'b1;
    run_burst(0, 32'h500, 3, 32'h60, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0 || xt !== 0) begin n_fail++; $display("FAIL iso_xtalk: got timeouts=%0d xtalk=%0d expected 0/0", to, xt); end
    run_burst(1, 32'h900, 1, 32'hE0, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0) begin n_fail++; $display("FAIL iso_late_grant: got timeouts=%0d expected 0", to); end
    n_checks++; if (beat_q.size() !== 4) begin n_fail++; $display("FAIL iso_nbeats: got %0d expected 4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== ((i < 3) ? 32'h60 + i : 32'hE0)) begin n_fail++; $display("FAIL iso_beat%0d: got %h expected %h", i, beat_q[i], (i < 3) ? 32'h60 + i : 32'hE0); end
    end
  endtask

  task automatic test_bvalid_with_last();
    int to, xt, sb, hb;
    run_burst(0, 32'h600, 2, 32'h30, -1, 0, 1, 2'b10, 1'b1, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0 || hb !== 0) begin n_fail++; $display("FAIL bv_last: got timeouts=%0d bad_resp=%0d expected 0/0", to, hb); end
  endtask

  task automatic test_reset_mid();
    int to, xt, sb, hb;
    beat_q.delete(); awa_q.delete(); last_q.delete();
    run_burst(0, 32'h40, 4, 32'h50, -1, 0, 0, 2'b00, 1'b0, 2, to, xt, sb, hb);
    n_checks++; if (beat_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_pre_beats: got %0d expected 2", beat_q.size()); end
    ARESETn = 1'b0;
    clear_inputs();
    @(posedge ACLK); #1;
    n_checks++; if ({S_AWREADY, S_WREADY, S_BVALID, S_BRESP} !== 8'h00) begin n_fail++; $display("FAIL rstmid_sout: got %h expected 00", {S_AWREADY, S_WREADY, S_BVALID, S_BRESP}); end
    n_checks++; if ({M_AWVALID, M_WVALID, M_WLAST} !== 3'b000 || M_AWADDR !== 32'h0) begin n_fail++; $display("FAIL rstmid_mout: got v=%b addr=%h expected 000/0", {M_AWVALID, M_WVALID, M_WLAST}, M_AWADDR); end
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    beat_q.delete(); awa_q.delete(); last_q.delete();
    run_burst(1, 32'h80, 2, 32'h90, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (to !== 0 || beat_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_after: got timeouts=%0d beats=%0d expected 0/2", to, beat_q.size()); end
    n_checks++; if (beat_q.size() == 2 && (beat_q[1] !== 32'h91 || awa_q[1] !== 32'h80)) begin n_fail++; $display("FAIL rstmid_after_data: got %h@%h expected 91@80", beat_q[1], awa_q[1]); end
  endtask

`ifdef AXI_WR_ARB_STATS_EN
  task automatic test_stats();
    int to, xt, sb, hb;
    do_reset();
    for (int i = 0; i < 3; i++) run_burst(1, 32'h700, 1, 32'h11, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    run_burst(0, 32'h800, 2, 32'h22, -1, 0, 0, 2'b00, 1'b0, -1, to, xt, sb, hb);
    n_checks++; if (STAT_BURSTS !== {16'd3, 16'd1}) begin n_fail++; $display("FAIL stats: got %h expected %h", STAT_BURSTS, {16'd3, 16'd1}); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_isolation();
    test_bvalid_with_last();
    test_reset_mid();
`ifdef AXI_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Round-robin write arbiter that shares one AXI-style write port (AW/W/B, single outstanding burst) of the on-chip memory slave among NUM_M masters.
- Grants one master per burst, forwards its address and data beats, and returns the slave's one-cycle BVALID pulse to that master as a proper VALID/READY response.
- Sits between the detection-pipeline write masters (DMA, result writer) and the memory slave.

Parameters:
NUM_M, 2, number of upstream masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; synchronous, active-low
S_AWADDR  in  NUM_M*ADDR_W  master i address at [i*ADDR_W +: ADDR_W]
S_AWVALID  in  NUM_M  per-master address valid
S_AWREADY  out  NUM_M  per-master address ready
S_WDATA  in  NUM_M*DATA_W  per-master write data
S_WVALID  in  NUM_M  per-master data valid
S_WLAST  in  NUM_M  per-master last beat
S_WREADY  out  NUM_M  per-master data ready
S_BVALID  out  NUM_M  per-master response valid
S_BRESP  out  2  response code, valid for granted master
S_BREADY  in  NUM_M  per-master response ready
M_AWADDR  out  ADDR_W  address to slave
M_AWVALID  out  1  address valid to slave
M_AWREADY  in  1  slave address ready
M_WDATA  out  DATA_W  data to slave
M_WVALID  out  1  data valid to slave
M_WLAST  out  1  last beat to slave
M_WREADY  in  1  slave data ready
M_BVALID  in  1  slave response pulse (no BREADY on slave)
M_BRESP  in  2  slave response code

Behaviour:
- Reset: state IDLE, rr pointer 0, grant 0, M_AWADDR 0. All S_*READY, S_BVALID, M_AWVALID, M_WVALID and M_WLAST are 0. S_BRESP is 0.
- IDLE: if any S_AWVALID, pick the first requester at or after the pointer, wrapping. Register the grant and go to ADDR on the next cycle. Arbitration latency is 1 cycle.
- ADDR: M_AWVALID = S_AWVALID[g] and S_AWREADY[g] = M_AWREADY. On handshake, latch the address into a register and go to DATA.
- M_AWADDR comes from that register and holds stable from ADDR until the state returns to IDLE. The slave samples the address during data beats.
- DATA: M_WDATA, M_WVALID and M_WLAST come from master g; S_WREADY[g] = M_WREADY. A beat is M_WVALID && M_WREADY. A beat with WLAST set moves to WAIT_B.
- WAIT_B: wait for M_BVALID, capture M_BRESP, then go to RESP. If M_BVALID arrives in the same cycle as the last-beat handshake, it is also captured.
- RESP: S_BVALID[g] = 1 and S_BRESP = captured value, held until S_BREADY[g]. Then pointer = (g+1) mod NUM_M and the state returns to IDLE.
- Non-granted masters always see READY=0 and BVALID=0. At most one bit of each S_* output vector is ever set.
- Request changes after the grant register is loaded have no effect. A master dropping S_AWVALID in ADDR stalls the arbiter; no re-arbitration.
- Zero-data bursts are not supported; a burst ends only on a WLAST beat.
- Reset in any state: return to IDLE and drop all outputs the next cycle. Any in-flight burst is abandoned without a response.

Optional Feature:
- Macro: AXI_WR_ARB_STATS_EN.
- With it: extra output STAT_BURSTS (NUM_M*16), holding per-master 16-bit saturating counts of completed bursts. A burst counts on the RESP handshake. Counters clear on reset.
- Without it: the port and counters do not exist.

Decomposition:
- Package axi_arb_pkg holds:
  - state enum {IDLE, ADDR, DATA, WAIT_B, RESP};
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - CNT_W=16.
- Sub-module rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot grant and index.

Test Plan:
- Single burst: M0 writes 0x10 with 4 beats (0xA0..0xA3) -> M_AWADDR=0x10 held through beat 4; M0 gets S_BVALID with BRESP=00; pointer moves to 1.
- Simultaneous requests from M0 and M1 after reset -> M0 served first, then M1. Repeated simultaneous requests alternate 0,1,0,1.
- Back-pressure: M_WREADY low for 3 cycles mid-burst -> S_WREADY[g] low and no beat lost. Also S_BREADY delayed 5 cycles -> S_BVALID held with BRESP stable.
- Non-granted master asserts AWVALID/WVALID during another burst -> its READY stays 0 until grant; no data reaches slave.
- Reset asserted in DATA after beat 2 -> next cycle all outputs 0 and state IDLE; a new request is granted normally.
- With AXI_WR_ARB_STATS_EN: 3 bursts from M1 and 1 from M0 -> STAT_BURSTS = {16'd3, 16'd1}.
